iq_avg_bram_writer: RTL and testbench
=====================================

# iq_avg_bram_writer

Fabric-side writer for a shared 32-bit × 1024 snapshot BRAM. Software reads that BRAM over the processor bus. On an arm pulse the block accumulates a streaming I/Q sample pair over 2^LOG_AVG valid samples. It then writes the packed average {I, Q} into port A of the BRAM and repeats until NUM_WORDS words are written, then flags done. It sits between the channelizer's I/Q stream and the shared BRAM's fabric port, feeding IQ-average snapshots to software.

## Interface
- LOG_AVG, 8, log2 of samples averaged per word; legal range 0..15.
- NUM_WORDS, 1024, words per snapshot; legal range 1..1024.
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- arm  in  1  single-cycle pulse; starts or restarts a snapshot.
- valid_in  in  1  qualifies i_in/q_in this cycle.
- i_in  in  16  signed I sample.
- q_in  in  16  signed Q sample.
- bram_we  out  1  port A write enable.
- bram_en_a  out  1  port A enable; always equals bram_we (write-only master).
- bram_addr  out  10  port A word address.
- bram_wr_data  out  32  {I_avg[15:0], Q_avg[15:0]}.
- busy  out  1  snapshot in progress.
- done  out  1  snapshot complete; held until the next arm or rst.

## Operation
- States: IDLE, ACC, DONE.
  - IDLE -> ACC on arm.
  - ACC -> DONE on the write of word NUM_WORDS-1.
  - DONE -> ACC on arm.
- On arm in any state: clear both accumulators, the sample count and the word index to 0; clear done; enter ACC.
  - Arm during ACC aborts the snapshot and restarts it. Words already written stay in the BRAM.
- In ACC, each valid_in cycle adds the sign-extended i_in and q_in to 16+LOG_AVG-bit signed accumulators and increments the sample count.
- Group complete: the valid sample that brings the count to 2^LOG_AVG.
  - On that sample: sum = acc + sample. Register sum >>> LOG_AVG (arithmetic shift, floor), take the low 16 bits of each of I and Q into bram_wr_data, and register the word index into bram_addr.
  - In the same cycle the accumulators and sample count restart from 0, so there are no dead cycles and no dropped samples.
- Word index increments after each write. No wrap: after word NUM_WORDS-1, further valid_in is ignored until arm.
- valid_in in IDLE or DONE is ignored.
- arm coinciding with a group-complete sample: arm wins. No write occurs and the sample is discarded.
- No overflow is possible: the accumulator width covers 2^LOG_AVG full-scale samples.

## Timing
- Reset values (registered):
  - bram_we, bram_en_a, bram_addr, bram_wr_data, busy, done: all 0.
  - State: IDLE.
- Reset mid-snapshot drops any pending write. bram_we is 0 in the cycle after rst.
- Write latency: bram_we/bram_en_a are high for exactly one cycle, the cycle after the group-complete sample. bram_addr and bram_wr_data are valid in that cycle.
- Consecutive writes are possible every cycle when LOG_AVG=0 and valid_in is held high.
- busy:
  - Rises the cycle after arm.
  - Falls in the cycle after the final write strobe, the same cycle done rises.
- Throughput: one sample per clk, sustained.

## Configuration
- IQ_AVG_ROUND_EN defined:
  - Add 2^(LOG_AVG-1) to each sum before the shift (round half up).
  - Saturate the shifted result to [-32768, 32767].
  - With LOG_AVG=0 there is no rounding and the result is the sample itself.
- IQ_AVG_ROUND_EN undefined: floor (truncate toward −∞) and wrap to 16 bits. Saturation is unnecessary in this mode because floor never exceeds range.

## Test plan
- Reset: assert rst 3 cycles during ACC -> all outputs 0, no bram_we in the following 20 cycles while valid_in=1.
- Basic average, LOG_AVG=2, NUM_WORDS=2: I=4,8,12,16 and Q=-1,-2,-3,-3, each with valid_in=1 -> one write at addr 0, data 0x000A_FFFD. With IQ_AVG_ROUND_EN: 0x000A_FFFE.
- Gapped valid, LOG_AVG=2: the same 4 samples interleaved with valid_in=0 cycles -> an identical word. The strobe occurs exactly 1 cycle after the 4th valid sample.
- Full snapshot, LOG_AVG=0, NUM_WORDS=1024, valid_in held high, i_in=n, q_in=-n -> 1024 back-to-back writes, addr 0..1023. done rises the cycle after the addr-1023 write, and no further writes occur.
- Abort, LOG_AVG=3: arm after 5 writes plus 3 samples -> next write at addr 0, averaging only post-arm samples. done stays 0 until the restarted snapshot completes.
- Saturation with IQ_AVG_ROUND_EN, LOG_AVG=1: I=32767,32767 -> I_avg=0x7FFF (no wrap to 0x8000).

Source files
------------

// File: rtl/iq_avg_bram_writer.sv
// Averages 2^LOG_AVG valid I/Q samples per word and writes NUM_WORDS words to BRAM port A (IQ_AVG_ROUND_EN: round half up + saturate).
// Write strobe one cycle after the group-completing sample; no backpressure, one sample per clock sustained.
module iq_avg_bram_writer #(
    parameter int LOG_AVG   = 8,
    parameter int NUM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        arm,
    input  logic        valid_in,
    input  logic [15:0] i_in,
    input  logic [15:0] q_in,
    output logic        bram_we,
    output logic        bram_en_a,
    output logic [9:0]  bram_addr,
    output logic [31:0] bram_wr_data,
    output logic        busy,
    output logic        done
);

    localparam int AW = 16 + LOG_AVG;
    localparam int SW = AW + 1;
    localparam int CW = LOG_AVG + 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'((2 ** LOG_AVG) - 1);
    localparam logic [9:0]    LAST_WORD = 10'(NUM_WORDS - 1);

    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

    state_t                state_q;
    logic signed [AW-1:0]  acc_i_q, acc_q_q;
    logic [CW-1:0]         cnt_q;
    logic [9:0]            word_q;
    logic                  fin_q;
    logic                  bram_we_q;
    logic [9:0]            addr_q;
    logic [31:0]           data_q;
    logic                  busy_q;
    logic                  done_q;

    logic signed [SW-1:0]  sum_i_d, sum_q_d;
    logic [15:0]           avg_i_d, avg_q_d;

    assign sum_i_d = SW'(acc_i_q) + SW'($signed(i_in));
    assign sum_q_d = SW'(acc_q_q) + SW'($signed(q_in));

`ifdef IQ_AVG_ROUND_EN
    localparam logic signed [SW-1:0] RND  = SW'((2 ** LOG_AVG) >> 1);
    localparam logic signed [SW-1:0] MAXV = SW'(32767);
    localparam logic signed [SW-1:0] MINV = SW'(-32768);

    function automatic logic [15:0] sat16(input logic signed [SW-1:0] v);
        if (v > MAXV)      return 16'h7FFF;
        else if (v < MINV) return 16'h8000;
        else               return 16'(v);
    endfunction

    assign avg_i_d = sat16((sum_i_d + RND) >>> LOG_AVG);
    assign avg_q_d = sat16((sum_q_d + RND) >>> LOG_AVG);
`else
    // Floor of a sum of in-range samples is always in range, so plain truncation suffices.
    assign avg_i_d = 16'(sum_i_d >>> LOG_AVG);
    assign avg_q_d = 16'(sum_q_d >>> LOG_AVG);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            acc_i_q   <= '0;
            acc_q_q   <= '0;
            cnt_q     <= '0;
            word_q    <= '0;
            fin_q     <= 1'b0;
            bram_we_q <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            bram_we_q <= 1'b0;
            if (fin_q) begin
                fin_q  <= 1'b0;
                busy_q <= 1'b0;
                done_q <= 1'b1;
            end
            // Arm overrides everything, including a coincident group-complete sample.
            if (arm) begin
                state_q <= ACC;
                acc_i_q <= '0;
                acc_q_q <= '0;
                cnt_q   <= '0;
                word_q  <= '0;
                fin_q   <= 1'b0;
                busy_q  <= 1'b1;
                done_q  <= 1'b0;
            end else if (state_q == ACC && valid_in) begin
                if (cnt_q == CNT_LAST) begin
                    acc_i_q   <= '0;
                    acc_q_q   <= '0;
                    cnt_q     <= '0;
                    bram_we_q <= 1'b1;
                    addr_q    <= word_q;
                    data_q    <= {avg_i_d, avg_q_d};
                    if (word_q == LAST_WORD) begin
                        state_q <= DONE;
                        fin_q   <= 1'b1;
                    end else begin
                        word_q <= word_q + 10'd1;
                    end
                end else begin
                    acc_i_q <= acc_i_q + AW'($signed(i_in));
                    acc_q_q <= acc_q_q + AW'($signed(q_in));
                    cnt_q   <= cnt_q + CW'(1);
                end
            end
        end
    end

    assign bram_we      = bram_we_q;
    assign bram_en_a    = bram_we_q;
    assign bram_addr    = addr_q;
    assign bram_wr_data = data_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule

// File: tb/tb_iq_avg_bram_writer.sv
// Directed bench: four writer instances with different averaging depths share the sample stream, each with its own arm.
module tb_iq_avg_bram_writer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, valid_in;
    logic [15:0] i_in, q_in;
    logic        arm_a, arm_b, arm_c, arm_d;

    logic        we_a, en_a, busy_a, done_a;
    logic [9:0]  addr_a;
    logic [31:0] data_a;
    logic        we_b, en_b, busy_b, done_b;
    logic [9:0]  addr_b;
    logic [31:0] data_b;
    logic        we_c, en_c, busy_c, done_c;
    logic [9:0]  addr_c;
    logic [31:0] data_c;
    logic        we_d, en_d, busy_d, done_d;
    logic [9:0]  addr_d;
    logic [31:0] data_d;

`ifdef IQ_AVG_ROUND_EN
    localparam logic [31:0] EXP_BASIC = 32'h000A_FFFE;
    localparam logic [31:0] EXP_RND   = 32'h0004_FFFD;
`else
    localparam logic [31:0] EXP_BASIC = 32'h000A_FFFD;
    localparam logic [31:0] EXP_RND   = 32'h0003_FFFC;
`endif

    iq_avg_bram_writer #(.LOG_AVG(2), .NUM_WORDS(2)) u_a (
        .clk(clk), .rst(rst), .arm(arm_a), .valid_in(valid_in), .i_in(i_in), .q_in(q_in),
        .bram_we(we_a), .bram_en_a(en_a), .bram_addr(addr_a), .bram_wr_data(data_a),
        .busy(busy_a), .done(done_a));

    iq_avg_bram_writer #(.LOG_AVG(0), .NUM_WORDS(1024)) u_b (
        .clk(clk), .rst(rst), .arm(arm_b), .valid_in(valid_in), .i_in(i_in), .q_in(q_in),
        .bram_we(we_b), .bram_en_a(en_b), .bram_addr(addr_b), .bram_wr_data(data_b),
        .busy(busy_b), .done(done_b));

    iq_avg_bram_writer #(.LOG_AVG(3), .NUM_WORDS(8)) u_c (
        .clk(clk), .rst(rst), .arm(arm_c), .valid_in(valid_in), .i_in(i_in), .q_in(q_in),
        .bram_we(we_c), .bram_en_a(en_c), .bram_addr(addr_c), .bram_wr_data(data_c),
        .busy(busy_c), .done(done_c));

    iq_avg_bram_writer #(.LOG_AVG(1), .NUM_WORDS(4)) u_d (
        .clk(clk), .rst(rst), .arm(arm_d), .valid_in(valid_in), .i_in(i_in), .q_in(q_in),
        .bram_we(we_d), .bram_en_a(en_d), .bram_addr(addr_d), .bram_wr_data(data_d),
        .busy(busy_d), .done(done_d));

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic samp(input int iv, input int qv);
        valid_in = 1'b1;
        i_in     = 16'(iv);
        q_in     = 16'(qv);
        cyc();
    endtask

    task automatic idle();
        valid_in = 1'b0;
        cyc();
    endtask

    initial begin
        int nw;
        int bad;
        rst = 1'b1; valid_in = 1'b0; i_in = '0; q_in = '0;
        arm_a = 1'b0; arm_b = 1'b0; arm_c = 1'b0; arm_d = 1'b0;
        cyc(); cyc();
        check("rst_we", we_a, 0);
        check("rst_en", en_a, 0);
        check("rst_addr", addr_a, 0);
        check("rst_data", data_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        rst = 1'b0;
        cyc();

        // Basic average, LOG_AVG=2
        arm_a = 1'b1; cyc(); arm_a = 1'b0;
        check("arm_busy", busy_a, 1);
        check("arm_done", done_a, 0);
        samp(4, -1); samp(8, -2); samp(12, -3);
        check("basic_no_early", we_a, 0);
        samp(16, -3);
        valid_in = 1'b0;
        check("basic_we", we_a, 1);
        check("basic_en", en_a, 1);
        check("basic_addr", addr_a, 0);
        check("basic_data", data_a, EXP_BASIC);
        cyc();
        check("basic_we_pulse", we_a, 0);

        // Gapped valid: same word, strobe right after the 4th valid sample
        samp(4, -1); idle(); idle(); samp(8, -2); idle(); samp(12, -3); idle(); idle(); idle();
        check("gap_no_early", we_a, 0);
        samp(16, -3);
        valid_in = 1'b0;
        check("gap_we", we_a, 1);
        check("gap_addr", addr_a, 1);
        check("gap_data", data_a, EXP_BASIC);
        check("gap_busy_at_strobe", busy_a, 1);
        check("gap_done_at_strobe", done_a, 0);
        cyc();
        check("final_we_off", we_a, 0);
        check("final_busy", busy_a, 0);
        check("final_done", done_a, 1);
        nw = 0;
        for (int k = 0; k < 6; k++) begin
            samp(5, 5);
            if (we_a) nw++;
        end
        valid_in = 1'b0;
        check("done_ignores_valid", nw, 0);
        check("done_held", done_a, 1);

        // Reset mid-snapshot
        arm_a = 1'b1; cyc(); arm_a = 1'b0;
        samp(1, 1); samp(2, 2); samp(3, 3);
        valid_in = 1'b1;
        rst = 1'b1;
        cyc(); cyc(); cyc();
        check("mid_rst_we", we_a, 0);
        check("mid_rst_en", en_a, 0);
        check("mid_rst_addr", addr_a, 0);
        check("mid_rst_data", data_a, 0);
        check("mid_rst_busy", busy_a, 0);
        check("mid_rst_done", done_a, 0);
        rst = 1'b0;
        nw = 0;
        for (int k = 0; k < 20; k++) begin
            samp(7, 7);
            if (we_a) nw++;
        end
        valid_in = 1'b0;
        check("post_rst_no_write", nw, 0);

        // Full snapshot, LOG_AVG=0, back-to-back writes
        arm_b = 1'b1; cyc(); arm_b = 1'b0;
        bad = 0;
        for (int n = 0; n < 1024; n++) begin
            samp(n, -n);
            if (!(we_b === 1'b1 && en_b === 1'b1 && addr_b === 10'(n) &&
                  data_b === {16'(n), 16'(-n)}))
                bad++;
            if (n == 1023 && (busy_b !== 1'b1 || done_b !== 1'b0)) bad++;
        end
        check("full_words_bad", bad, 0);
        samp(0, 0);
        check("full_done", done_b, 1);
        check("full_busy", busy_b, 0);
        check("full_we_off", we_b, 0);
        nw = 0;
        for (int k = 0; k < 10; k++) begin
            samp(9, 9);
            if (we_b) nw++;
        end
        valid_in = 1'b0;
        check("full_no_more_writes", nw, 0);

        // Abort, LOG_AVG=3: 5 writes + 3 samples, then re-arm
        arm_c = 1'b1; cyc(); arm_c = 1'b0;
        nw = 0;
        for (int k = 0; k < 40; k++) begin
            samp(8, -8);
            if (we_c) nw++;
        end
        check("abort_pre_writes", nw, 5);
        check("abort_pre_addr", addr_c, 4);
        check("abort_pre_data", data_c, 32'h0008_FFF8);
        samp(100, 100); samp(100, 100); samp(100, 100);
        valid_in = 1'b0;
        arm_c = 1'b1; cyc(); arm_c = 1'b0;
        check("abort_busy", busy_c, 1);
        check("abort_done", done_c, 0);
        for (int k = 0; k < 7; k++) samp(16, -16);
        check("abort_no_early", we_c, 0);
        samp(16, -16);
        valid_in = 1'b0;
        check("abort_we", we_c, 1);
        check("abort_addr", addr_c, 0);
        check("abort_data", data_c, 32'h0010_FFF0);
        check("abort_done_low", done_c, 0);

        // Arm coinciding with a group-complete sample: arm wins, no write
        for (int k = 0; k < 7; k++) samp(16, -16);
        valid_in = 1'b1; i_in = 16'd16; q_in = 16'hFFF0; arm_c = 1'b1;
        cyc();
        arm_c = 1'b0; valid_in = 1'b0;
        check("arm_vs_group_we", we_c, 0);
        for (int k = 0; k < 8; k++) samp(24, -24);
        valid_in = 1'b0;
        check("rearm_we", we_c, 1);
        check("rearm_addr", addr_c, 0);
        check("rearm_data", data_c, 32'h0018_FFE8);

        // Extremes and rounding, LOG_AVG=1
        arm_d = 1'b1; cyc(); arm_d = 1'b0;
        samp(32767, -32768); samp(32767, -32768);
        valid_in = 1'b0;
        check("sat_we", we_d, 1);
        check("sat_data", data_d, 32'h7FFF_8000);
        samp(3, -3); samp(4, -4);
        valid_in = 1'b0;
        check("rnd_addr", addr_d, 1);
        check("rnd_data", data_d, EXP_RND);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
